// File: rtl/bank_swap_ctrl.sv
// bank_swap_ctrl: ping-pong frame-buffer controller that swaps banks only on VGA frame boundaries
module bank_swap_ctrl #(
    parameter int FRAME_BITS = 30000,
    parameter int CNT_W      = $clog2(FRAME_BITS)
) (
    input  logic        CLK_40,
    input  logic        reset,
    input  logic        chip_select,
    input  logic        SPI_clk_en,
    input  logic        frame_end,
    output logic        read_bank1,
    output logic        read_bank2,
    output logic        write_bank2,
    output logic        video_data_ready,
    output logic        VGA_sync_en,
    output logic [15:0] frame_count,
    output logic        overrun
);
    typedef enum logic [1:0] {IDLE, FILL, PEND} state_t;
    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic             take;
    logic             last;
    assign take = SPI_clk_en & video_data_ready;
    assign last = bit_cnt == CNT_W'(FRAME_BITS - 1);
    // Fill the write bank, hold it complete until frame_end, then hand it to the display
    always_ff @(posedge CLK_40) begin
        if (reset) begin
            state            <= IDLE;
            bit_cnt          <= '0;
            read_bank1       <= 1'b0;
            read_bank2       <= 1'b0;
            write_bank2      <= 1'b0;
            video_data_ready <= 1'b0;
            VGA_sync_en      <= 1'b0;
            frame_count      <= '0;
            overrun          <= 1'b0;
        end else begin
            overrun <= SPI_clk_en & chip_select & ~video_data_ready;
            case (state)
                IDLE: begin
                    state            <= FILL;
                    VGA_sync_en      <= 1'b1;
                    video_data_ready <= 1'b0;
                end
                FILL: begin
                    if (take && last) begin
                        bit_cnt          <= '0;
                        state            <= PEND;
                        video_data_ready <= 1'b0;
                    end else begin
                        bit_cnt          <= take ? bit_cnt + CNT_W'(1) : bit_cnt;
                        video_data_ready <= chip_select;
                    end
                end
                PEND: begin
                    video_data_ready <= 1'b0;
                    if (frame_end) begin
                        write_bank2 <= ~write_bank2;
                        read_bank1  <= ~write_bank2;
                        read_bank2  <= write_bank2;
                        frame_count <= frame_count + 16'd1;
                        state       <= FILL;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
